// File: rtl/prog_pulse_gen.sv
// rtl/prog_pulse_gen.sv - programmable period/duty pulse generator (single, burst, continuous)
//
// Ports:
//   clk_in     system clock
//   rst        synchronous active-high reset
//   start      trigger level; rising edge starts a run, level sustains continuous mode
//   mode       0 single, 1 burst, 2 continuous, 3 single
//   period     period P in clk_in cycles (sampled only when a run starts)
//   high_cnt   high time H in clk_in cycles (sampled only when a run starts)
//   burst_len  pulse count N for burst mode (sampled only when a run starts)
//   clk_out    generated waveform, registered
//   busy       high while a run is in progress
//   done       one-cycle strobe at the end of a run

module prog_pulse_gen #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   period,
    input  logic [CNT_W-1:0]   high_cnt,
    input  logic [BURST_W-1:0] burst_len,
    output logic               clk_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_BURST  = 2'd1;
    localparam logic [1:0] MODE_CONT   = 2'd2;

    state_t             state;
    state_t             state_n;
    logic               start_d;
    logic               start_rise;
    logic [1:0]         mode_r;
    logic [CNT_W-1:0]   per_r;
    logic [CNT_W-1:0]   high_r;
    logic [BURST_W-1:0] len_r;
    // pcnt holds the 1-based index of the cycle currently being output
    // within the period; it never exceeds per_r, so full-scale P cannot wrap.
    logic [CNT_W-1:0]   pcnt;
    // bcnt counts completed periods in burst mode; it stops at len_r-1.
    logic [BURST_W-1:0] bcnt;

    logic [CNT_W-1:0]   p_clamp;
    logic [CNT_W-1:0]   h_clamp;
    logic [BURST_W-1:0] n_clamp;
    logic               period_end;
    logic               run_more;

    assign start_rise = start & ~start_d;

    always_comb begin
        p_clamp = (period < CNT_W'(2)) ? CNT_W'(2) : period;
        if (high_cnt == '0) begin
            h_clamp = CNT_W'(1);
        end else if (high_cnt >= p_clamp) begin
            h_clamp = p_clamp - CNT_W'(1);
        end else begin
            h_clamp = high_cnt;
        end
        n_clamp = (burst_len == '0) ? BURST_W'(1) : burst_len;
    end

    always_comb begin
        period_end = (pcnt == per_r);
        case (mode_r)
            MODE_BURST: run_more = (bcnt != (len_r - BURST_W'(1)));
            MODE_CONT:  run_more = start;
            default:    run_more = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start_rise) state_n = RUN;
            RUN:  if (period_end && !run_more) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            start_d <= 1'b0;
            mode_r  <= MODE_SINGLE;
            per_r   <= '0;
            high_r  <= '0;
            len_r   <= '0;
            pcnt    <= '0;
            bcnt    <= '0;
            clk_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            start_d <= start;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        // Mode 3 is folded into single so later logic only sees 0..2.
                        mode_r  <= (mode == 2'd3) ? MODE_SINGLE : mode;
                        per_r   <= p_clamp;
                        high_r  <= h_clamp;
                        len_r   <= n_clamp;
                        pcnt    <= CNT_W'(1);
                        bcnt    <= '0;
                        clk_out <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (period_end) begin
                        if (run_more) begin
                            pcnt    <= CNT_W'(1);
                            clk_out <= 1'b1;
                            if (mode_r == MODE_BURST) begin
                                bcnt <= bcnt + BURST_W'(1);
                            end
                        end else begin
                            pcnt    <= '0;
                            bcnt    <= '0;
                            clk_out <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        pcnt    <= pcnt + CNT_W'(1);
                        // Next cycle index is pcnt+1; it is high while that is <= H.
                        clk_out <= (pcnt < high_r);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
